// File: rtl/sdpram_be.sv
// sdpram_be: simple dual-port RAM with byte-enabled write port A and a pipelined, valid-strobed read port B.
// Define SDPRAM_BE_FWD_EN for write-first same-address collisions; the default build is read-first.
module sdpram_be #(
  parameter int    MemSizeWords    = 32,
  parameter int    AddrBusWidth    = 5,
  parameter int    DataBusWidth    = 32,
  parameter int    ByteWidth       = 8,
  parameter int    ReadLatency     = 1,
  parameter string MemoryPrimitive = "block"
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [AddrBusWidth-1:0]             addr_a,
  input  logic                                we_a,
  input  logic [DataBusWidth/ByteWidth-1:0]   be_a,
  input  logic [DataBusWidth-1:0]             w_data_a,
  input  logic [AddrBusWidth-1:0]             addr_b,
  input  logic                                re_b,
  output logic [DataBusWidth-1:0]             r_data_b,
  output logic                                r_valid_b
);
  localparam int NumBytes = DataBusWidth / ByteWidth;

  if (ReadLatency < 1 || ReadLatency > 4 || (DataBusWidth % ByteWidth) != 0 ||
      (MemoryPrimitive != "block" && MemoryPrimitive != "distributed")) begin : g_bad_param
    $error("sdpram_be: illegal parameter set");
  end

  // Contents start at zero and are never touched by rst.
  logic [DataBusWidth-1:0] r_mem [MemSizeWords] = '{default: '0};

  logic w_wr_hit;
  logic w_rd_hit;
  logic [DataBusWidth-1:0] w_rd_word;

  assign w_wr_hit = !rst && we_a && (32'(addr_a) < 32'(MemSizeWords));
  assign w_rd_hit = 32'(addr_b) < 32'(MemSizeWords);

  always_ff @(posedge clk) begin
    if (w_wr_hit)
      for (int i = 0; i < NumBytes; i++)
        if (be_a[i]) r_mem[addr_a][i*ByteWidth +: ByteWidth] <= w_data_a[i*ByteWidth +: ByteWidth];
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_hit) w_rd_word = r_mem[addr_b];
`ifdef SDPRAM_BE_FWD_EN
    // Write-first bypass: enabled lanes of a same-edge write override the stored word.
    if (w_rd_hit && w_wr_hit && (addr_a == addr_b))
      for (int i = 0; i < NumBytes; i++)
        if (be_a[i]) w_rd_word[i*ByteWidth +: ByteWidth] = w_data_a[i*ByteWidth +: ByteWidth];
`endif
  end

  logic [ReadLatency:1]                   r_vld_pipe;
  logic [ReadLatency:1][DataBusWidth-1:0] r_dat_pipe;

  // Data stages load only behind a valid bit, so the last stage holds its previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= re_b;
      if (re_b) r_dat_pipe[1] <= w_rd_word;
      for (int s = 2; s <= ReadLatency; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_dat_pipe[s] <= r_dat_pipe[s-1];
      end
    end
  end

  assign r_data_b  = r_dat_pipe[ReadLatency];
  assign r_valid_b = r_vld_pipe[ReadLatency];

endmodule

// File: tb/tb_sdpram_be.sv
// Bench for sdpram_be: four instances (ReadLatency 1..4, 24 words) share one stimulus stream;
// a reference memory feeds per-instance expected-result queues checked as results emerge.
module tb_sdpram_be;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int NB = DW / BW;
  localparam int MW = 24;
  localparam int NL = 4;

  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic          we_a = 1'b0;
  logic          re_b = 1'b0;
  logic [NB-1:0] be_a = '0;
  logic [DW-1:0] w_data_a = '0;
  logic [DW-1:0] r_data [NL];
  logic          r_valid [NL];

  for (genvar g = 0; g < NL; g++) begin : g_dut
    sdpram_be #(
      .MemSizeWords(MW), .AddrBusWidth(AW), .DataBusWidth(DW), .ByteWidth(BW),
      .ReadLatency(g + 1), .MemoryPrimitive("block")
    ) u_dut (
      .clk(clk), .rst(rst), .addr_a(addr_a), .we_a(we_a), .be_a(be_a), .w_data_a(w_data_a),
      .addr_b(addr_b), .re_b(re_b), .r_data_b(r_data[g]), .r_valid_b(r_valid[g])
    );
  end

  logic [DW-1:0] mdl [MW];
  exp_t          exp_q [NL][$];
  logic [DW-1:0] last_d [NL];
  exp_t          mon_e;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  logic          rst_d = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  // Output monitor: reset values, result data/timing, no spurious or missing pulses, hold when idle.
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (rst_d) begin
        total++;
        if (r_valid[k] !== 1'b0 || r_data[k] !== '0) begin
          bad++;
          $display("FAIL rst_out lat%0d got valid=%b data=%h want 0/0", k + 1, r_valid[k], r_data[k]);
        end
        exp_q[k].delete();
        last_d[k] = '0;
      end else if (r_valid[k] === 1'b1) begin
        total++;
        if (exp_q[k].size() == 0) begin
          bad++;
          $display("FAIL spurious lat%0d cyc=%0d got data=%h want no pulse", k + 1, cyc, r_data[k]);
        end else begin
          mon_e = exp_q[k].pop_front();
          if (mon_e.due != cyc || r_data[k] !== mon_e.d) begin
            bad++;
            $display("FAIL rd_data lat%0d got cyc=%0d data=%h want cyc=%0d data=%h",
                     k + 1, cyc, r_data[k], mon_e.due, mon_e.d);
          end
        end
        last_d[k] = r_data[k];
      end else begin
        if (exp_q[k].size() != 0 && exp_q[k][0].due <= cyc) begin
          total++;
          bad++;
          $display("FAIL missing lat%0d cyc=%0d got valid=%b want data=%h", k + 1, cyc, r_valid[k], exp_q[k][0].d);
          void'(exp_q[k].pop_front());
        end
        total++;
        if (r_data[k] !== last_d[k]) begin
          bad++;
          $display("FAIL hold lat%0d got data=%h want %h", k + 1, r_data[k], last_d[k]);
        end
      end
    end
  end

  // Drive one cycle of stimulus, update the reference model, then wait past the next falling edge.
  task automatic step(input logic r, input logic we, input logic [NB-1:0] be, input logic [AW-1:0] aw,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ar);
    logic [DW-1:0] rd;
    rst = r; we_a = we; be_a = be; addr_a = aw; w_data_a = wd; re_b = re; addr_b = ar;
    if (!r) begin
      if (re) begin
        rd = (int'(ar) < MW) ? mdl[ar] : '0;
`ifdef SDPRAM_BE_FWD_EN
        if (we && aw == ar && int'(ar) < MW)
          for (int i = 0; i < NB; i++) if (be[i]) rd[i*BW +: BW] = wd[i*BW +: BW];
`endif
        for (int k = 0; k < NL; k++) exp_q[k].push_back('{due: cyc + k + 1, d: rd});
      end
      if (we && int'(aw) < MW)
        for (int i = 0; i < NB; i++) if (be[i]) mdl[aw][i*BW +: BW] = wd[i*BW +: BW];
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    step(1'b0, 1'b1, be, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic test_reset();
    // Requests presented during reset must be ignored.
    step(1'b1, 1'b1, 4'hF, 5'd2, 32'h12345678, 1'b1, 5'd2);
    step(1'b1, 1'b1, 4'hF, 5'd2, 32'h12345678, 1'b1, 5'd2);
    for (int k = 0; k < NL; k++) begin
      total++;
      if (r_valid[k] !== 1'b0 || r_data[k] !== '0) begin
        bad++;
        $display("FAIL reset_state lat%0d got valid=%b data=%h want 0/0", k + 1, r_valid[k], r_data[k]);
      end
    end
    rd(5'h1B);
    total++;
    if (r_valid[0] !== 1'b1 || r_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL first_read got valid=%b data=%h want 1/00000000", r_valid[0], r_data[0]);
    end
    rd(5'd2);
    idle(5);
  endtask

  task automatic test_byte_en();
    wr(5'd3, 4'hF, 32'hDEADBEEF);
    wr(5'd3, 4'h1, 32'h000000C5);
    rd(5'd3);
    total++;
    if (r_valid[0] !== 1'b1 || r_data[0] !== 32'hDEADBEC5) begin
      bad++;
      $display("FAIL byte_en got valid=%b data=%h want 1/deadbec5", r_valid[0], r_data[0]);
    end
    wr(5'd3, 4'h0, 32'h55555555);
    rd(5'd3);
    wr(5'd3, 4'hA, 32'h12345678);
    rd(5'd3);
    idle(5);
  endtask

  task automatic test_latency_sweep();
    for (int a = 0; a < 8; a++) wr(AW'(a), 4'hF, 32'(a * 16'h1111));
    for (int a = 0; a < 8; a++) rd(AW'(a));
    total++;
    if (r_valid[0] !== 1'b1 || r_data[0] !== 32'h00007777) begin
      bad++;
      $display("FAIL sweep_last got valid=%b data=%h want 1/00007777", r_valid[0], r_data[0]);
    end
    idle(6);
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
`ifdef SDPRAM_BE_FWD_EN
    want = 32'h1111AAAA;
`else
    want = 32'h11111111;
`endif
    wr(5'd7, 4'hF, 32'h11111111);
    step(1'b0, 1'b1, 4'h3, 5'd7, 32'hAAAAAAAA, 1'b1, 5'd7);
    total++;
    if (r_data[0] !== want) begin
      bad++;
      $display("FAIL collision got data=%h want %h", r_data[0], want);
    end
    rd(5'd7);
    total++;
    if (r_data[0] !== 32'h1111AAAA) begin
      bad++;
      $display("FAIL after_collision got data=%h want 1111aaaa", r_data[0]);
    end
    // Back-to-back colliding writes with reads in flight behind them.
    step(1'b0, 1'b1, 4'hC, 5'd7, 32'hBBBBBBBB, 1'b1, 5'd7);
    step(1'b0, 1'b1, 4'hF, 5'd7, 32'h01020304, 1'b1, 5'd7);
    rd(5'd7);
    idle(5);
  endtask

  task automatic test_out_of_range();
    wr(5'd6, 4'hF, 32'h06060606);
    wr(5'd30, 4'hF, 32'hFFFFFFFF);
    wr(5'd23, 4'hF, 32'h23232323);
    wr(5'd24, 4'hF, 32'hEEEEEEEE);
    rd(5'd30);
    total++;
    if (r_data[0] !== 32'h0) begin
      bad++;
      $display("FAIL oob_read got data=%h want 00000000", r_data[0]);
    end
    rd(5'd6);
    rd(5'd14);
    rd(5'd23);
    rd(5'd24);
    rd(5'd0);
    rd(5'd31);
    idle(5);
  endtask

  task automatic test_reset_midflight();
    wr(5'd9, 4'hF, 32'hCAFEF00D);
    rd(5'd9);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    total++;
    if (r_valid[2] !== 1'b0 || r_data[2] !== '0) begin
      bad++;
      $display("FAIL midflight_rst got valid=%b data=%h want 0/0", r_valid[2], r_data[2]);
    end
    idle(6);
    rd(5'd9);
    rd(5'd3);
    idle(5);
  endtask

  initial begin
    for (int i = 0; i < MW; i++) mdl[i] = '0;
    for (int k = 0; k < NL; k++) last_d[k] = '0;
    test_reset();
    test_byte_en();
    test_latency_sweep();
    test_collision();
    test_out_of_range();
    test_reset_midflight();
    idle(6);
    for (int k = 0; k < NL; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin
        bad++;
        $display("FAIL drain lat%0d got pending=%0d want 0", k + 1, exp_q[k].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
